// File: rtl/reg_writeback_unit_pkg.sv
// Shared widths, drain FSM encodings and the queued-entry payload for the
// register-file writeback unit.
package reg_writeback_unit_pkg;

    localparam int unsigned WORD_SIZE = 16;
    localparam int unsigned NUM_REGS  = 4;
    localparam int unsigned IDXW      = $clog2(NUM_REGS);

    localparam logic [1:0] WB_IDLE   = 2'd0;
    localparam logic [1:0] WB_SETUP  = 2'd1;
    localparam logic [1:0] WB_STROBE = 2'd2;
    localparam logic [1:0] WB_HOLD   = 2'd3;

    typedef struct packed {
        logic [IDXW-1:0]      idx;
        logic [WORD_SIZE-1:0] data;
    } wb_entry_t;

    // One-hot register mask for a destination index.
    function automatic logic [NUM_REGS-1:0] idx_onehot(input logic [IDXW-1:0] idx);
        idx_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/reg_writeback_unit_if.sv
// Producer handshakes, register-file write port and forwarding query of the
// writeback unit; master = result sources / consumer, slave = the unit.
interface reg_writeback_unit_if;
    import reg_writeback_unit_pkg::*;

    logic                 alu_valid;
    logic [IDXW-1:0]      alu_idx;
    logic [WORD_SIZE-1:0] alu_data;
    logic                 alu_ready;

    logic                 mem_valid;
    logic [IDXW-1:0]      mem_idx;
    logic [WORD_SIZE-1:0] mem_data;
    logic                 mem_ready;

    logic                 writeM;
    logic [IDXW-1:0]      writeIdx;
    logic [WORD_SIZE-1:0] writeData;

    logic [NUM_REGS-1:0]  pending;
    logic [IDXW-1:0]      q_idx;
    logic                 q_hit;
    logic [WORD_SIZE-1:0] q_data;

    modport master (
        output alu_valid, alu_idx, alu_data,
        input  alu_ready,
        output mem_valid, mem_idx, mem_data,
        input  mem_ready,
        input  writeM, writeIdx, writeData,
        input  pending,
        output q_idx,
        input  q_hit, q_data
    );

    modport slave (
        input  alu_valid, alu_idx, alu_data,
        output alu_ready,
        input  mem_valid, mem_idx, mem_data,
        output mem_ready,
        output writeM, writeIdx, writeData,
        output pending,
        input  q_idx,
        output q_hit, q_data
    );

endinterface

// File: rtl/reg_writeback_unit_wb_fifo.sv
// In-order result FIFO; exposes every slot in age order (0 = head/oldest)
// so the parent can build the pending mask and youngest-match forwarding.
module reg_writeback_unit_wb_fifo
    import reg_writeback_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  wb_entry_t        push_entry,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output wb_entry_t        age_entry [DEPTH],
    output logic [DEPTH-1:0] age_valid
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    wb_entry_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (!do_push && do_pop) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) mem[wr_ptr] <= push_entry;
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            age_entry[k] = mem[rd_ptr + PW'(k)];
            age_valid[k] = (CW'(k) < count);
        end
    end

endmodule

// File: rtl/reg_writeback_unit.sv
// Collects ALU/load results into an in-order FIFO and drains them to the
// register file with a setup/strobe/hold write pulse; forwards queued values.
module reg_writeback_unit
    import reg_writeback_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    reg_writeback_unit_if.slave  bus
);

    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    wb_entry_t            push_entry;
    wb_entry_t            age_entry [DEPTH];
    logic [DEPTH-1:0]     age_valid;

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic                 writem_q;
    logic                 writem_nxt;
    logic [IDXW-1:0]      widx_q;
    logic [IDXW-1:0]      widx_nxt;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [WORD_SIZE-1:0] wdata_nxt;

    logic [NUM_REGS-1:0]  pend;
    logic [WORD_SIZE-1:0] fwd_data;

    // Loads win a collision; readiness never looks at a same-cycle pop.
    assign bus.mem_ready = !full;
    assign bus.alu_ready = !full && !bus.mem_valid;
    assign push = (bus.mem_valid && bus.mem_ready) || (bus.alu_valid && bus.alu_ready);

    always_comb begin
        if (bus.mem_valid) begin
            push_entry.idx  = bus.mem_idx;
            push_entry.data = bus.mem_data;
        end else begin
            push_entry.idx  = bus.alu_idx;
            push_entry.data = bus.alu_data;
        end
    end

    reg_writeback_unit_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .full       (full),
        .empty      (empty),
        .age_entry  (age_entry),
        .age_valid  (age_valid)
    );

    // Drain sequencer: the head stays queued until HOLD so it is always
    // either forwardable or already committed.
    always_comb begin
        state_nxt  = state;
        writem_nxt = 1'b0;
        widx_nxt   = widx_q;
        wdata_nxt  = wdata_q;
        pop        = 1'b0;
        case (state)
            WB_IDLE: begin
                if (!empty) begin
                    widx_nxt  = age_entry[0].idx;
                    wdata_nxt = age_entry[0].data;
                    state_nxt = WB_SETUP;
                end
            end
            WB_SETUP: begin
                writem_nxt = 1'b1;
                state_nxt  = WB_STROBE;
            end
            WB_STROBE: begin
                state_nxt = WB_HOLD;
            end
            WB_HOLD: begin
                pop       = 1'b1;
                state_nxt = WB_IDLE;
            end
            default: begin
                state_nxt = WB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= WB_IDLE;
            writem_q <= 1'b0;
            widx_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state    <= state_nxt;
            writem_q <= writem_nxt;
            widx_q   <= widx_nxt;
            wdata_q  <= wdata_nxt;
        end
    end

    assign bus.writeM    = writem_q;
    assign bus.writeIdx  = widx_q;
    assign bus.writeData = wdata_q;

    // Scan oldest to youngest so the last match is the value that survives.
    always_comb begin
        pend     = '0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (age_valid[k]) begin
                pend = pend | idx_onehot(age_entry[k].idx);
                if (age_entry[k].idx == bus.q_idx) fwd_data = age_entry[k].data;
            end
        end
    end

    assign bus.pending = pend;
    assign bus.q_hit   = pend[bus.q_idx];
    assign bus.q_data  = fwd_data;

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Randomised and directed bench for reg_writeback_unit against a schedule-based
// reference model (accept time -> load/strobe/pop times).
module tb_reg_writeback_unit;
    import reg_writeback_unit_pkg::*;

    localparam int unsigned DEPTH = 4;

    typedef struct {
        int                   acc;
        int                   ld;
        logic [IDXW-1:0]      idx;
        logic [WORD_SIZE-1:0] data;
    } ment_t;

    typedef struct {
        logic [IDXW-1:0]      idx;
        logic [WORD_SIZE-1:0] data;
    } wr_t;

    logic clk;
    logic reset;

    reg_writeback_unit_if bus();

    reg_writeback_unit #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ment_t                model [$];
    wr_t                  obs [$];
    int                   cyc;
    int                   n_checks;
    int                   n_fail;
    int                   pulses;
    logic [WORD_SIZE-1:0] rf     [NUM_REGS];
    logic [WORD_SIZE-1:0] exp_rf [NUM_REGS];

    // Register file as seen by the consumer: written on the rising edge of writeM.
    always @(posedge bus.writeM) begin
        rf[bus.writeIdx] = bus.writeData;
        obs.push_back('{bus.writeIdx, bus.writeData});
        pulses++;
    end

    // An entry accepted at edge A is loaded at L = max(A+1, prev L+4),
    // strobes at edge L+1 and leaves the queue at edge L+3.
    function automatic int occ();
        int n = 0;
        foreach (model[i]) if (model[i].acc <= cyc && cyc < model[i].ld + 3) n++;
        return n;
    endfunction

    function automatic logic [NUM_REGS-1:0] exp_pending();
        logic [NUM_REGS-1:0] p = '0;
        foreach (model[i]) if (model[i].acc <= cyc && cyc < model[i].ld + 3) p[model[i].idx] = 1'b1;
        return p;
    endfunction

    function automatic logic exp_writem();
        logic w = 1'b0;
        foreach (model[i]) if (cyc == model[i].ld + 1) w = 1'b1;
        return w;
    endfunction

    function automatic void exp_wout(output logic [IDXW-1:0] ei, output logic [WORD_SIZE-1:0] ed);
        ei = '0;
        ed = '0;
        foreach (model[i]) if (model[i].ld <= cyc) begin
            ei = model[i].idx;
            ed = model[i].data;
        end
    endfunction

    function automatic void exp_query(input logic [IDXW-1:0] q, output logic eh, output logic [WORD_SIZE-1:0] ed);
        eh = 1'b0;
        ed = '0;
        foreach (model[i]) if (model[i].acc <= cyc && cyc < model[i].ld + 3 && model[i].idx == q) begin
            eh = 1'b1;
            ed = model[i].data;
        end
    endfunction

    function automatic void model_push(input logic [IDXW-1:0] i, input logic [WORD_SIZE-1:0] d);
        ment_t e;
        e.acc  = cyc + 1;
        e.ld   = e.acc + 1;
        if (model.size() > 0 && model[model.size()-1].ld + 4 > e.ld) e.ld = model[model.size()-1].ld + 4;
        e.idx  = i;
        e.data = d;
        model.push_back(e);
    endfunction

    // One clock: compare every output against the model, then advance.
    task automatic tick(output logic acc_mem, output logic acc_alu);
        logic                 exp_full;
        logic [IDXW-1:0]      ei;
        logic [WORD_SIZE-1:0] ed;
        logic                 eh;
        logic [WORD_SIZE-1:0] eqd;
        int                   exp_n;
        ment_t                ew;
        #1;
        exp_full = (occ() == DEPTH);
        n_checks++;
        if (bus.mem_ready !== !exp_full) begin
            n_fail++;
            $display("FAIL mem_ready cyc=%0d got %b exp %b", cyc, bus.mem_ready, !exp_full);
        end
        n_checks++;
        if (bus.alu_ready !== (!exp_full && !bus.mem_valid)) begin
            n_fail++;
            $display("FAIL alu_ready cyc=%0d got %b exp %b", cyc, bus.alu_ready, !exp_full && !bus.mem_valid);
        end
        n_checks++;
        if (bus.writeM !== exp_writem()) begin
            n_fail++;
            $display("FAIL writeM cyc=%0d got %b exp %b", cyc, bus.writeM, exp_writem());
        end
        exp_wout(ei, ed);
        n_checks++;
        if (bus.writeIdx !== ei || bus.writeData !== ed) begin
            n_fail++;
            $display("FAIL write_port cyc=%0d got %0d/%h exp %0d/%h", cyc, bus.writeIdx, bus.writeData, ei, ed);
        end
        n_checks++;
        if (bus.pending !== exp_pending()) begin
            n_fail++;
            $display("FAIL pending cyc=%0d got %b exp %b", cyc, bus.pending, exp_pending());
        end
        exp_query(bus.q_idx, eh, eqd);
        n_checks++;
        if (bus.q_hit !== eh || bus.q_data !== eqd) begin
            n_fail++;
            $display("FAIL forward cyc=%0d q=%0d got %b/%h exp %b/%h", cyc, bus.q_idx, bus.q_hit, bus.q_data, eh, eqd);
        end
        acc_mem = bus.mem_valid && !exp_full && !reset;
        acc_alu = bus.alu_valid && !exp_full && !bus.mem_valid && !reset;
        if (acc_mem)      model_push(bus.mem_idx, bus.mem_data);
        else if (acc_alu) model_push(bus.alu_idx, bus.alu_data);
        @(posedge clk);
        if (reset) begin
            model.delete();
            cyc = 0;
        end else begin
            cyc++;
        end
        @(negedge clk);
        exp_n = 0;
        foreach (model[i]) if (model[i].ld + 1 == cyc) begin
            exp_n++;
            ew = model[i];
        end
        n_checks++;
        if (obs.size() != exp_n) begin
            n_fail++;
            $display("FAIL commit_count cyc=%0d got %0d exp %0d", cyc, obs.size(), exp_n);
        end else if (exp_n == 1) begin
            exp_rf[ew.idx] = ew.data;
            n_checks++;
            if (obs[0].idx !== ew.idx || obs[0].data !== ew.data) begin
                n_fail++;
                $display("FAIL commit cyc=%0d got %0d/%h exp %0d/%h", cyc, obs[0].idx, obs[0].data, ew.idx, ew.data);
            end
        end
        obs.delete();
    endtask

    task automatic idle(input int n);
        logic am, aa;
        repeat (n) tick(am, aa);
    endtask

    task automatic send_alu(input logic [IDXW-1:0] i, input logic [WORD_SIZE-1:0] d);
        logic am, aa;
        int   n = 0;
        bus.alu_valid = 1'b1;
        bus.alu_idx   = i;
        bus.alu_data  = d;
        do begin
            tick(am, aa);
            n++;
        end while (!aa && n < 24);
        bus.alu_valid = 1'b0;
        n_checks++;
        if (!aa) begin
            n_fail++;
            $display("FAIL send_alu_timeout idx=%0d got no accept exp accept within 24 cycles", i);
        end
    endtask

    task automatic do_reset();
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model.delete();
        obs.delete();
        cyc = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if (bus.writeM !== 1'b0 || bus.writeIdx !== '0 || bus.writeData !== '0) begin
            n_fail++;
            $display("FAIL reset_write_port got %b/%0d/%h exp 0/0/0000", bus.writeM, bus.writeIdx, bus.writeData);
        end
        n_checks++;
        if (bus.pending !== '0 || bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state got pend=%b rdy=%b%b exp 0000/11", bus.pending, bus.mem_ready, bus.alu_ready);
        end
        idle(2);
    endtask

    task automatic test_single();
        int p0;
        do_reset();
        p0 = pulses;
        send_alu(2'd2, 16'h1234);
        n_checks++;
        if (bus.pending !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_pending got %b exp 0100", bus.pending);
        end
        idle(8);
        n_checks++;
        if (rf[2] !== 16'h1234 || pulses - p0 != 1) begin
            n_fail++;
            $display("FAIL single_commit got %h/%0d pulses exp 1234/1", rf[2], pulses - p0);
        end
    endtask

    task automatic test_collision();
        logic am, aa;
        do_reset();
        bus.mem_valid = 1'b1; bus.mem_idx = 2'd1; bus.mem_data = 16'hAAAA;
        bus.alu_valid = 1'b1; bus.alu_idx = 2'd3; bus.alu_data = 16'h5555;
        #1;
        n_checks++;
        if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_ready got alu=%b mem=%b exp alu=0 mem=1", bus.alu_ready, bus.mem_ready);
        end
        tick(am, aa);
        bus.mem_valid = 1'b0;
        tick(am, aa);
        bus.alu_valid = 1'b0;
        n_checks++;
        if (aa !== 1'b1 || bus.pending !== 4'b1010) begin
            n_fail++;
            $display("FAIL collision_alu_accept got acc=%b pend=%b exp 1/1010", aa, bus.pending);
        end
        idle(12);
        n_checks++;
        if (rf[1] !== 16'hAAAA || rf[3] !== 16'h5555) begin
            n_fail++;
            $display("FAIL collision_regs got r1=%h r3=%h exp AAAA/5555", rf[1], rf[3]);
        end
    endtask

    task automatic test_back_to_back();
        int first_acc;
        int p0;
        do_reset();
        p0 = pulses;
        send_alu(2'd0, 16'h0A00);
        first_acc = cyc;
        for (int k = 1; k < 4; k++) send_alu(IDXW'(k), WORD_SIZE'($urandom));
        #1;
        n_checks++;
        if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ready got alu=%b mem=%b exp 0/0", bus.alu_ready, bus.mem_ready);
        end
        send_alu(2'd2, 16'hBEEF);
        n_checks++;
        if (cyc != first_acc + 5) begin
            n_fail++;
            $display("FAIL fifth_accept got cycle %0d exp %0d", cyc - first_acc, 5);
        end
        idle(24);
        n_checks++;
        if (pulses - p0 != 5 || bus.pending !== '0 || rf[2] !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL b2b_drain got %0d pulses pend=%b r2=%h exp 5/0000/BEEF", pulses - p0, bus.pending, rf[2]);
        end
    endtask

    task automatic test_same_reg();
        do_reset();
        send_alu(2'd0, 16'h0001);
        send_alu(2'd0, 16'h0002);
        bus.q_idx = 2'd0;
        #1;
        n_checks++;
        if (bus.q_hit !== 1'b1 || bus.q_data !== 16'h0002) begin
            n_fail++;
            $display("FAIL youngest_forward got %b/%h exp 1/0002", bus.q_hit, bus.q_data);
        end
        idle(12);
        n_checks++;
        if (bus.pending[0] !== 1'b0 || rf[0] !== 16'h0002) begin
            n_fail++;
            $display("FAIL same_reg_final got pend0=%b r0=%h exp 0/0002", bus.pending[0], rf[0]);
        end
    endtask

    task automatic test_reset_mid_strobe();
        logic am, aa;
        int   p0;
        do_reset();
        send_alu(2'd1, 16'hC0DE);
        send_alu(2'd2, 16'hF00D);
        tick(am, aa);
        n_checks++;
        if (bus.writeM !== 1'b1) begin
            n_fail++;
            $display("FAIL strobe_before_reset got %b exp 1", bus.writeM);
        end
        reset = 1'b1;
        tick(am, aa);
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.writeM !== 1'b0 || bus.pending !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_strobe got wm=%b pend=%b exp 0/0000", bus.writeM, bus.pending);
        end
        p0 = pulses;
        idle(16);
        n_checks++;
        if (pulses != p0) begin
            n_fail++;
            $display("FAIL pulses_after_reset got %0d exp 0", pulses - p0);
        end
    endtask

    task automatic test_empty_query();
        do_reset();
        bus.q_idx = 2'd1;
        #1;
        n_checks++;
        if (bus.q_hit !== 1'b0 || bus.q_data !== '0) begin
            n_fail++;
            $display("FAIL empty_query got %b/%h exp 0/0000", bus.q_hit, bus.q_data);
        end
        idle(1);
    endtask

    task automatic test_random();
        logic am, aa;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (!bus.mem_valid && ($urandom % 4) == 0) begin
                bus.mem_valid = 1'b1;
                bus.mem_idx   = IDXW'($urandom);
                bus.mem_data  = WORD_SIZE'($urandom);
            end
            if (!bus.alu_valid && ($urandom % 2) == 0) begin
                bus.alu_valid = 1'b1;
                bus.alu_idx   = IDXW'($urandom);
                bus.alu_data  = WORD_SIZE'($urandom);
            end
            bus.q_idx = IDXW'($urandom);
            tick(am, aa);
            if (am) bus.mem_valid = 1'b0;
            if (aa) bus.alu_valid = 1'b0;
        end
        bus.mem_valid = 1'b0;
        bus.alu_valid = 1'b0;
        idle(40);
        for (int r = 0; r < NUM_REGS; r++) begin
            n_checks++;
            if (rf[r] !== exp_rf[r]) begin
                n_fail++;
                $display("FAIL random_regfile r%0d got %h exp %h", r, rf[r], exp_rf[r]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        pulses   = 0;
        cyc      = 0;
        reset    = 1'b1;
        bus.alu_valid = 1'b0; bus.alu_idx = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_idx = '0; bus.mem_data = '0;
        bus.q_idx     = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            rf[r]     = '0;
            exp_rf[r] = '0;
        end
        test_reset();
        test_single();
        test_collision();
        test_back_to_back();
        test_same_reg();
        test_reset_mid_strobe();
        test_empty_query();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_writeback_unit.md
Name: reg_writeback_unit

Overview:
- Producer side of the register-file write port.
- Accepts destination-register results from the ALU and memory stages over valid/ready handshakes and buffers them in an in-order FIFO.
- Drains the FIFO into the register file's write port (writeM strobe, writeIdx, writeData) with a clean setup/strobe/hold pulse. The register file writes on the rising edge of writeM.
- Exposes a per-register pending scoreboard and a forwarding lookup for queued-but-unwritten values.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- WORD, `WORD_SIZE (16), data width, taken from opcodes.v.
- NREGS, `NUM_REGS (4), register count; index width IDXW = 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- alu_valid  in  1  ALU result offered.
- alu_idx  in  IDXW  ALU destination register.
- alu_data  in  WORD  ALU result.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid && alu_ready.
- mem_valid  in  1  load result offered.
- mem_idx  in  IDXW  load destination register.
- mem_data  in  WORD  load data.
- mem_ready  out  1  load result accepted when mem_valid && mem_ready.
- writeM  out  1  register-file write strobe (registered).
- writeIdx  out  IDXW  register-file write index (registered).
- writeData  out  WORD  register-file write data (registered).
- pending  out  NREGS  bit r = 1 while any FIFO entry targets register r.
- q_idx  in  IDXW  forwarding query index.
- q_hit  out  1  combinational; 1 when pending[q_idx].
- q_data  out  WORD  combinational; data of the youngest FIFO entry with idx == q_idx; 0 when no hit.

Behaviour:
- Reset (synchronous, dominates everything):
  - FIFO emptied (count = 0, pointers = 0), FSM to IDLE.
  - writeM = 0, writeIdx = 0, writeData = 0, pending = 0.
  - Asserted mid-strobe: writeM is 0 the next cycle and the in-flight entry is discarded.
- Enqueue: at most one entry per cycle.
  - mem_ready = !full.
  - alu_ready = !full && !mem_valid. Memory has priority on collision; the ALU source holds its valid until accepted.
  - readies depend only on full; no bypass when a pop and a push coincide at full.
- FIFO:
  - Count width clog2(DEPTH+1); pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leaves count unchanged.
- Drain FSM:
  - IDLE: if !empty, load writeIdx/writeData from head and go to SETUP; writeM = 0.
  - SETUP: writeM = 0, outputs stable; go to STROBE.
  - STROBE: writeM = 1 (rising edge commits the write); go to HOLD.
  - HOLD: writeM = 0, idx/data held; pop head; go to IDLE.
- Throughput and latency:
  - One write per 4 cycles.
  - Entry accepted at edge N: SETUP at N+1, writeM high during N+2→N+3, popped at the end of N+4.
- Head entry remains in the FIFO (and in pending/forwarding) until the HOLD pop, so there is no gap in which a value is neither forwarded nor in the register file.
- pending is recomputed from valid entries each cycle. Two queued writes to the same register leave pending set until both pop.
- Forwarding: youngest matching entry wins. Entries are committed oldest-first, so the final register value equals the youngest.
- writeIdx/writeData are never changed outside IDLE→SETUP, and hold their last values in IDLE.

Decomposition:
- WORD_SIZE and NUM_REGS come from the existing opcodes.v defines.
- FSM state encodings (IDLE, SETUP, STROBE, HOLD) are added there as `WB_* defines.
- One sub-module: wb_fifo (storage, pointers, count, full/empty, per-entry idx/valid taps for pending and youngest-match search).

Test Plan:
- Reset then ALU push idx=2, data=0x1234 → writeM rises exactly once, 2 cycles after accept, with writeIdx=2, writeData=0x1234. pending[2] is 1 from accept through the pop cycle. Register 2 reads 0x1234.
- mem_valid and alu_valid together (mem idx1=0xAAAA, alu idx3=0x5555) → mem accepted, alu_ready=0. ALU accepted next cycle. Writes occur in order reg1 then reg3.
- Push 5 entries back-to-back with DEPTH=4 → 4 accepted, then ready=0 until first HOLD pop. The 5th is accepted the cycle after count drops, and all 5 writes are committed in order.
- Push reg0=0x0001 then reg0=0x0002, query q_idx=0 → q_hit=1, q_data=0x0002. After both commits, pending[0]=0 and reg0=0x0002.
- Assert reset during STROBE with 2 entries queued → next cycle writeM=0 and pending=0. No further writeM pulses occur.
- Query q_idx=1 with empty FIFO → q_hit=0, q_data=0.
